// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: symbol length, phase index width
// and the dibit bundle passed from feeder to modulator.
package qpsk_pkg;

  localparam int SAMPLES_PER_SYM_DEF = 100;
  localparam int IDX_W = 7;

  typedef struct packed {
    logic e;
    logic o;
  } dibit_t;

  function automatic logic [IDX_W-1:0] idx_inc(
    input logic [IDX_W-1:0] idx,
    input logic [IDX_W-1:0] last
  );
    return (idx == last) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/qpsk_dibit_fifo.sv
// Circular dibit FIFO with occupancy count; push and pop
// are ignored when they would overflow or underflow.
module qpsk_dibit_fifo
  import qpsk_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [1:0]    din_i,
  input  logic          pop_i,
  output logic [1:0]    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  dibit_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] wr_d;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rd_d;
  logic [LW-1:0] lvl_q;
  logic [LW-1:0] lvl_d;
  logic          push_ok;
  logic          pop_ok;
  dibit_t        din;

  assign full_o  = (lvl_q == LVL_FULL);
  assign empty_o = (lvl_q == '0);
  assign level_o = lvl_q;
  assign dout_o  = mem_q[rd_q];
  assign din     = din_i;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (push_ok) begin
      wr_d = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  // Storage needs no reset: level gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/qpsk_dibit_feeder.sv
// Pairs serial bits into dibits, buffers them, and releases one
// dibit per symbol alongside the sample tick and phase index.
module qpsk_dibit_feeder
  import qpsk_pkg::*;
#(
  parameter int DIV = 16,
  parameter int SAMPLES_PER_SYM = qpsk_pkg::SAMPLES_PER_SYM_DEF,
  parameter int FIFO_DEPTH = 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1,
  localparam int DW = $clog2(DIV)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic             E,
  output logic             O,
  output logic             sample_tick,
  output logic [IDX_W-1:0] sample_idx,
  output logic             sym_strobe,
  output logic             underrun,
  output logic [LW-1:0]    fifo_level
);

  localparam logic [DW-1:0]    DIV_MAX = DW'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SAMPLES_PER_SYM - 1);

  logic             half_q;
  logic             half_d;
  logic             hold_q;
  logic             hold_d;
  logic [DW-1:0]    div_q;
  logic [DW-1:0]    div_d;
  logic             tick_q;
  logic             tick_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             strobe_q;
  logic             strobe_d;
  logic             und_q;
  logic             und_d;
  dibit_t           sym_q;
  dibit_t           sym_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_dout;
  dibit_t           head;
  dibit_t           pair;
  logic             xfer;
  logic             push;
  logic             pop;
  logic             div_wrap;
  logic             boundary;

  assign bit_ready = !(half_q && fifo_full);
  assign xfer      = bit_valid && bit_ready;
  assign push      = xfer && half_q;

  assign div_wrap  = (div_q == DIV_MAX);
  assign boundary  = div_wrap && (idx_q == IDX_MAX);
  assign pop       = boundary && !fifo_empty;

  assign head      = fifo_dout;
  assign pair.e    = hold_q;
  assign pair.o    = bit_in;

  qpsk_dibit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .push_i  (push),
    .din_i   (pair),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    half_d = half_q;
    hold_d = hold_q;
    if (xfer) begin
      half_d = !half_q;
      if (!half_q) begin
        hold_d = bit_in;
      end
    end
  end

  // Everything below is computed one cycle early so that tick,
  // index, strobe and symbol all change on the same edge.
  always_comb begin
    div_d    = div_wrap ? '0 : div_q + 1'b1;
    tick_d   = div_wrap;
    idx_d    = idx_q;
    strobe_d = boundary;
    und_d    = boundary && fifo_empty;
    sym_d    = sym_q;
    if (div_wrap) begin
      idx_d = idx_inc(idx_q, IDX_MAX);
    end
    if (pop) begin
      sym_d = head;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      half_q   <= 1'b0;
      hold_q   <= 1'b0;
      div_q    <= '0;
      tick_q   <= 1'b0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      und_q    <= 1'b0;
      sym_q    <= '0;
    end else begin
      half_q   <= half_d;
      hold_q   <= hold_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      und_q    <= und_d;
      sym_q    <= sym_d;
    end
  end

  assign E           = sym_q.e;
  assign O           = sym_q.o;
  assign sample_tick = tick_q;
  assign sample_idx  = idx_q;
  assign sym_strobe  = strobe_q;
  assign underrun    = und_q;

endmodule

// File: tb/tb_qpsk_dibit_feeder.sv
// Bench for qpsk_dibit_feeder: clock-count reference model,
// boundary scoreboard and directed scenario checks.
module tb_qpsk_dibit_feeder;

  localparam int DIV   = 16;
  localparam int SPS   = 100;
  localparam int DEPTH = 4;
  localparam int SYM   = DIV * SPS;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_ready;
  logic       E;
  logic       O;
  logic       sample_tick;
  logic [6:0] sample_idx;
  logic       sym_strobe;
  logic       underrun;
  logic [2:0] fifo_level;

  always #5 Clk = ~Clk;

  qpsk_dibit_feeder #(
    .DIV             (DIV),
    .SAMPLES_PER_SYM (SPS),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .E           (E),
    .O           (O),
    .sample_tick (sample_tick),
    .sample_idx  (sample_idx),
    .sym_strobe  (sym_strobe),
    .underrun    (underrun),
    .fifo_level  (fifo_level)
  );

  int n_checks = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  typedef struct {
    bit e;
    bit o;
    bit und;
  } exp_t;

  // Model: time since reset in clocks; symbols drawn from a queue.
  int       t = 0;
  bit       m_half = 0;
  bit       m_hold = 0;
  bit       m_e = 0;
  bit       m_o = 0;
  bit       m_und = 0;
  bit       m_strobe = 0;
  bit       m_tick = 0;
  int       m_idx = 0;
  bit [1:0] m_q[$];
  exp_t     sb[$];
  bit [1:0] slog[$];
  int       und_cnt = 0;

  initial forever begin
    bit rdy;
    bit xfer;
    @(posedge Clk);
    rdy  = !(m_half && m_q.size() == DEPTH);
    xfer = bit_valid && rdy;
    if (Rst) begin
      t = 0; m_half = 0; m_hold = 0; m_q.delete(); sb.delete();
      m_e = 0; m_o = 0; m_und = 0; m_strobe = 0; m_tick = 0;
      m_idx = 0;
    end else begin
      t++;
      m_tick   = (t % DIV == 0);
      m_idx    = (t / DIV) % SPS;
      m_strobe = (t % SYM == 0);
      m_und    = 0;
      if (m_strobe) begin
        if (m_q.size() > 0) {m_e, m_o} = m_q.pop_front();
        else m_und = 1;
        sb.push_back('{m_e, m_o, m_und});
      end
      if (xfer) begin
        if (m_half) m_q.push_back({m_hold, bit_in});
        else m_hold = bit_in;
        m_half = !m_half;
      end
    end
  end

  initial forever begin
    exp_t x;
    @(negedge Clk);
    chk("ready", bit_ready, !(m_half && m_q.size() == DEPTH));
    chk("level", fifo_level, m_q.size());
    chk("tick", sample_tick, m_tick);
    chk("idx", sample_idx, m_idx);
    chk("strobe", sym_strobe, m_strobe);
    chk("underrun", underrun, m_und);
    chk("E", E, m_e);
    chk("O", O, m_o);
    if (underrun) und_cnt++;
    if (sym_strobe) begin
      slog.push_back({E, O});
      chk("sb_avail", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("sb_E", E, x.e);
        chk("sb_O", O, x.o);
        chk("sb_und", underrun, x.und);
      end
    end
  end

  task automatic send(input bit b, input int budget, output bit ok);
    bit r;
    ok = 0;
    bit_valid = 1'b1;
    bit_in = b;
    for (int i = 0; i < budget; i++) begin
      r = bit_ready;
      @(posedge Clk);
      if (r) begin
        ok = 1;
        break;
      end
      @(negedge Clk);
    end
    if (ok) @(negedge Clk);
    bit_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget,
                              output bit ok);
    int seen = 0;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (sym_strobe) seen++;
      if (seen >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    bit       ok;
    int       base;
    int       ubase;
    int       tacc;
    int       n;
    bit [1:0] race;
    bit       pat[8] = '{1, 0, 0, 1, 1, 1, 0, 0};
    bit [1:0] exp_sym[5] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b00};

    repeat (3) @(negedge Clk);
    Rst = 1'b0;

    base = slog.size();
    foreach (pat[i]) begin
      send(pat[i], 10, ok);
      chk("pair_accept", ok, 1);
    end
    wait_strobes(5, 5 * SYM + 50, ok);
    chk("pair_strobes", ok, 1);
    for (int k = 0; k < 5; k++) begin
      if (slog.size() > base + k) chk("pair_sym", slog[base + k], exp_sym[k]);
      else chk("pair_sym_missing", slog.size(), base + k + 1);
    end

    for (int i = 0; i < 9; i++) begin
      send(1'($urandom), 10, ok);
      chk("bp_fill_accept", ok, 1);
    end
    chk("bp_ready_low", bit_ready, 0);
    chk("bp_level_full", fifo_level, 4);
    tacc = ((t / SYM) + 1) * SYM + 1;
    send(1'($urandom), 2 * SYM, ok);
    chk("bp_held_accept", ok, 1);
    chk("bp_accept_time", t, tacc);
    chk("bp_level_after", fifo_level, 4);
    repeat (2) @(negedge Clk);
    chk("bp_level_once", fifo_level, 4);

    ubase = und_cnt;
    wait_strobes(5, 5 * SYM + 50, ok);
    chk("drain_strobes", ok, 1);
    chk("drain_underrun", und_cnt - ubase, 1);
    chk("drain_level", fifo_level, 0);

    race = {!m_e, !m_o};
    send(race[1], 10, ok);
    chk("race_first", ok, 1);
    for (int i = 0; i < 2 * SYM; i++) begin
      if ((t + 1) % SYM == 0) break;
      @(negedge Clk);
    end
    chk("race_align", (t + 1) % SYM, 0);
    bit_valid = 1'b1;
    bit_in = race[0];
    @(posedge Clk);
    @(negedge Clk);
    bit_valid = 1'b0;
    chk("race_strobe", sym_strobe, 1);
    chk("race_underrun", underrun, 1);
    chk("race_level", fifo_level, 1);
    wait_strobes(1, SYM + 50, ok);
    chk("race_next", ok, 1);
    chk("race_sym", {E, O}, race);
    chk("race_no_und", underrun, 0);

    for (int i = 0; i < 5; i++) begin
      send(1'($urandom), 10, ok);
      chk("rst_pre_accept", ok, 1);
    end
    repeat (20) @(negedge Clk);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_ready", bit_ready, 1);
    chk("rst_EO", {E, O}, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_idx", sample_idx, 0);
    chk("rst_strobe", sym_strobe, 0);
    chk("rst_und", underrun, 0);
    chk("rst_level", fifo_level, 0);
    Rst = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
      if (sample_tick) break;
    end
    chk("rst_first_tick", n, DIV);

    for (int i = 0; i < 12000; i++) begin
      int lim = (i < 6000) ? 299 : 1499;
      bit_valid = ($urandom_range(0, lim) == 0);
      bit_in = 1'($urandom);
      @(negedge Clk);
    end
    bit_valid = 1'b0;
    repeat (2) @(negedge Clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
